// File: rtl/mult_share_arbiter_pkg.sv
// Shared defaults and helpers for the time-shared multiplier arbiter.
// Latency: none (definitions only).
// Backpressure: n/a.

`ifndef MULT_SHARE_DEFAULTS
`define MULT_SHARE_DEFAULTS
`define MSA_BITS 8
`define MSA_NREQ 4
`define MSA_LAT  2
`define MSA_IDW  2
`endif

package mult_share_arbiter_pkg;

  localparam int DEF_BITS = `MSA_BITS;
  localparam int DEF_NREQ = `MSA_NREQ;
  localparam int DEF_LAT  = `MSA_LAT;
  localparam int DEF_IDW  = `MSA_IDW;

  // Modular add for round-robin indices. Callers guarantee x < n and y <= n,
  // so one conditional subtract replaces a general modulo.
  function automatic int wrap_add(int x, int y, int n);
    int s;
    s = x + y;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/result bundle between requesters, consumer and the shared multiplier.
// Latency: none (wiring only).
// Backpressure: req_ready per requester, res_ready from the single consumer.

interface mult_share_arbiter_if
  import mult_share_arbiter_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*BITS-1:0] req_a;
  logic [NREQ*BITS-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [2*BITS-1:0]    res_data;
  logic                 res_ready;
  logic                 busy;

  // Requester/consumer side.
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_data, busy
  );

endinterface

// File: rtl/mult_share_arbiter_mult_pipe.sv
// Staged unsigned multiplier carrying a valid bit and requester tag per stage.
// Latency: LAT cycles from the capturing edge to out_v.
// Backpressure: en low freezes every stage, including the outputs.

module mult_pipe
  import mult_share_arbiter_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int IDW  = DEF_IDW,
  parameter int LAT  = DEF_LAT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_v,
  input  logic [IDW-1:0]    in_id,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  output logic              out_v,
  output logic [IDW-1:0]    out_id,
  output logic [2*BITS-1:0] p
);

  localparam int PW = 2 * BITS;
  // Split point of operand b; the two halves give two partial products.
  localparam int H  = BITS / 2;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_lo_ext;
  logic [PW-1:0] b_hi_ext;
  logic [PW-1:0] pp_lo;
  logic [PW-1:0] pp_hi;
  logic [PW-1:0] s0_dat;

  logic [LAT-1:0] v_q;
  logic [IDW-1:0] id_q [LAT];
  logic [PW-1:0]  pr_q [LAT];
  logic [PW-1:0]  hi_q;

  assign a_ext    = PW'(a);
  assign b_lo_ext = PW'(b[H-1:0]);
  assign b_hi_ext = PW'(b[BITS-1:H]);
  assign pp_lo    = a_ext * b_lo_ext;
  assign pp_hi    = (a_ext * b_hi_ext) << H;

  // With a single stage the whole product is formed before the first register;
  // otherwise the two partials are registered and summed on the way into stage 1.
  assign s0_dat = (LAT == 1) ? (pp_lo + pp_hi) : pp_lo;

  // Stage registers: capture at stage 0, shift forward, hold everything when en is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q  <= '0;
      hi_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        id_q[i] <= '0;
        pr_q[i] <= '0;
      end
    end else if (en) begin
      v_q[0]  <= in_v;
      id_q[0] <= in_id;
      pr_q[0] <= s0_dat;
      hi_q    <= pp_hi;
      for (int i = 1; i < LAT; i++) begin
        v_q[i]  <= v_q[i-1];
        id_q[i] <= id_q[i-1];
        if (i == 1) pr_q[i] <= pr_q[0] + hi_q;
        else        pr_q[i] <= pr_q[i-1];
      end
    end
  end

  assign out_v  = v_q[LAT-1];
  assign out_id = id_q[LAT-1];
  assign p      = pr_q[LAT-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter time-sharing one pipelined multiplier among NREQ requesters.
// Latency: LAT cycles from acceptance to res_valid, plus one per stall cycle.
// Backpressure: res_valid && !res_ready freezes the pipe and drops every req_ready.

module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int NREQ = DEF_NREQ,
  parameter int LAT  = DEF_LAT,
  parameter int IDW  = DEF_IDW
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mult_share_arbiter_if.slave   bus
);

  // Wide enough to count 0..LAT entries plus the transient of issue-without-retire.
  localparam int CW = $clog2(LAT + 2);

  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  scan_idx;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_vld;
  logic            stall;
  logic            issue;
  logic            retire;
  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic [CW-1:0]   cnt_q;

  // Round-robin search: first valid requester at or after the pointer, with wrap.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'(wrap_add(int'(ptr_q), k, NREQ));
      if (!gnt_vld && bus.req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  // A held result blocks the whole pipe; reset_n gating keeps req_ready low in reset.
  assign stall  = bus.res_valid && !bus.res_ready;
  assign issue  = gnt_vld && !stall && reset_n;
  assign retire = bus.res_valid && bus.res_ready;

  // One-hot ready toward the granted requester only when it can actually issue.
  always_comb begin
    bus.req_ready = '0;
    if (issue) bus.req_ready[gnt_id] = 1'b1;
  end

  // Steer the granted requester's operands into the multiplier.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        op_a = bus.req_a[k*BITS +: BITS];
        op_b = bus.req_b[k*BITS +: BITS];
      end
    end
  end

  // Pointer moves past the winner on issue so every requester gets its turn.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else if (issue) ptr_q <= IDW'(wrap_add(int'(gnt_id), 1, NREQ));
  end

  // In-flight count; non-zero exactly when some stage holds a valid entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_q + CW'(issue) - CW'(retire);
  end

  assign bus.busy = (cnt_q != '0);

  mult_pipe #(
    .BITS (BITS),
    .IDW  (IDW),
    .LAT  (LAT)
  ) u_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (!stall),
    .in_v    (issue),
    .in_id   (gnt_id),
    .a       (op_a),
    .b       (op_b),
    .out_v   (bus.res_valid),
    .out_id  (bus.res_id),
    .p       (bus.res_data)
  );

endmodule
